rtc_seq_ctrl_param: RTL and testbench
=====================================

Name: rtc_seq_ctrl_param

Overview:
- Parametrised successor of the RTC top-level sequencer.
- Drives the RTC read/write function block with an address/data/direction stream, one register per transaction, advancing on in_flag_done.
- Adds parametrised register-field counts and bases, and registered step/state control with no combinational counter reset.
- Adds a per-transaction timeout with error recovery, a sequence-done pulse, and a busy flag.

Parameters:
AW, 8, address width.
DW, 8, data width.
N_TIME, 7, number of time/date registers (contiguous from TIME_BASE).
TIME_BASE, 8'h21, first time/date address.
N_TMR, 3, number of timer registers (contiguous from TMR_BASE).
TMR_BASE, 8'h41, first timer address.
TIMEOUT, 1023, max cycles a transaction may wait for in_flag_done (>=2).

Ports:
clk  in  1  system clock, all logic rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
in_flag_done  in  1  one-cycle pulse from the function block, meaning the current transaction is complete.
in_sw  in  3  mode switches: {sw2,sw1,sw0}.
out_funcion_conf  out  3  in_sw sampled at each READ_CTE end.
out_addr_ram_rtc  out  AW  transaction address.
out_dato_inicio  out  DW  write data for init-type transactions.
out_flag_inicio  out  1  1 = transaction uses out_dato_inicio.
out_funcion_w_r  out  1  1 = write, 0 = read.
out_en_funcion_rtc  out  1  transaction enable.
out_busy  out  1  1 while any sequence is active (all states except IDLE, GAP, ERROR).
out_seq_done  out  1  one-cycle pulse on the final done of any sequence.
out_error  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Registers: state, step index idx (5 bits), timeout counter, gap flag, conf register, error flag.
- Outputs are a decode of the registered state and idx.
- Reset values: state = IDLE, idx = 0, every output 0.
- IDLE lasts 1 cycle, then GAP, then INIT.
- Step rule: within a sequence en = 1. A done while en = 1 increments idx, and the new address is visible the next cycle. in_flag_done while en = 0 is ignored.
- On the final step's done: idx <- 0, out_seq_done = 1 for that cycle, and the next state is entered via GAP. GAP is exactly 1 cycle with en = 0 and all other outputs 0.
- INIT: 4 writes with flag_inicio = 1, as (addr, data): (02,10), (02,00), (10,D2), (00,00). Next state READ_CTE.
- READ_CTE: reads F0, then TIME_BASE..+N_TIME-1, then TMR_BASE..+N_TMR-1 (11 steps at defaults).
- At READ_CTE end, sample in_sw into out_funcion_conf and select the next state:
  - 001 -> CFG_HORA
  - 010 -> CFG_FECHA
  - 100 -> CFG_TIMER
  - any other value, including multiple bits set -> READ_CTE
- CFG_HORA: reads F2, then TMR_BASE..+N_TMR-1.
- CFG_FECHA: reads F1, TIME_BASE..+2, F2, then TMR_BASE..+N_TMR-1.
- CFG_TIMER: reads F1, then TIME_BASE..+N_TIME-1.
- CFG exit: at the end of each CFG sequence, if in_sw == 000 go to WR_HF (HORA/FECHA) or WR_TMR (TIMER); otherwise repeat the same CFG state.
- WR_HF: writes TIME_BASE..+N_TIME-1, then F1, with flag_inicio = 0 and data = 0. Next state READ_CTE.
- WR_TMR: writes TMR_BASE..+N_TMR-1, then F2, then (00,08) with flag_inicio = 1. Next state READ_CTE.
- Timeout counter:
  - Clears on each done and on state entry.
  - Increments while en = 1.
  - Reaching TIMEOUT without a done -> ERROR: error flag set, en = 0.
  - Done in the same cycle the count reaches TIMEOUT: done wins, no error.
- ERROR lasts 1 cycle, then GAP, then INIT.
- Reset mid-transaction: all outputs are 0 immediately (asynchronous), and the sequence restarts from IDLE.
- Switch changes mid-sequence have no effect; switches are sampled only at sequence end.

Test Plan:
- Reset release, done returned 3 cycles after each en -> addr/data sequence (02,10), (02,00), (10,D2), (00,00) with flag_inicio = 1 and w_r = 1; then 1 GAP cycle with en = 0; then READ_CTE addr F0, 21..27, 41..43 with w_r = 0; out_seq_done pulses twice.
- in_sw = 010 during READ_CTE -> CFG_FECHA reads F1, 21, 22, 23, F2, 41, 42, 43 repeating. Set in_sw = 000 -> WR_HF writes 21..27, F1, then READ_CTE resumes.
- in_sw = 100 then 000 -> WR_TMR writes 41, 42, 43, F2, then (00,08) with flag_inicio = 1.
- in_sw = 011 at READ_CTE end -> READ_CTE repeats, out_funcion_conf = 011.
- Withhold in_flag_done for TIMEOUT cycles -> out_error = 1 (sticky), en = 0, then GAP, then INIT restarts at (02,10). Also check done on exactly cycle TIMEOUT -> no error.
- Assert reset mid-WR_TMR -> all outputs 0 the same cycle; after release the sequence restarts from INIT step 0.

Source files
------------

// File: rtl/rtc_seq_ctrl_param_if.sv
// Bus between the RTC sequencer (master) and the RTC read/write function block (slave).
interface rtc_seq_ctrl_param_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          in_flag_done;
   logic [2:0]    in_sw;
   logic [2:0]    out_funcion_conf;
   logic [AW-1:0] out_addr_ram_rtc;
   logic [DW-1:0] out_dato_inicio;
   logic          out_flag_inicio;
   logic          out_funcion_w_r;
   logic          out_en_funcion_rtc;
   logic          out_busy;
   logic          out_seq_done;
   logic          out_error;

   modport master (
      input  in_flag_done, in_sw,
      output out_funcion_conf, out_addr_ram_rtc, out_dato_inicio, out_flag_inicio,
             out_funcion_w_r, out_en_funcion_rtc, out_busy, out_seq_done, out_error
   );

   modport slave (
      output in_flag_done, in_sw,
      input  out_funcion_conf, out_addr_ram_rtc, out_dato_inicio, out_flag_inicio,
             out_funcion_w_r, out_en_funcion_rtc, out_busy, out_seq_done, out_error
   );
endinterface

// File: rtl/rtc_seq_ctrl_param.sv
// RTC top-level sequencer: streams one register transaction per in_flag_done,
// with per-transaction timeout recovery, sequence-done pulse and busy flag.
module rtc_seq_ctrl_param #(
   parameter int            AW        = 8,
   parameter int            DW        = 8,
   parameter int            N_TIME    = 7,
   parameter logic [AW-1:0] TIME_BASE = AW'(8'h21),
   parameter int            N_TMR     = 3,
   parameter logic [AW-1:0] TMR_BASE  = AW'(8'h41),
   parameter int            TIMEOUT   = 1023
) (
   input  logic                 clk,
   input  logic                 reset,
   rtc_seq_ctrl_param_if.master bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_GAP, S_INIT, S_READ_CTE, S_CFG_HORA, S_CFG_FECHA,
      S_CFG_TIMER, S_WR_HF, S_WR_TMR, S_ERROR
   } state_t;

   localparam int            TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [AW-1:0] A_F0     = AW'(8'hF0);
   localparam logic [AW-1:0] A_F1     = AW'(8'hF1);
   localparam logic [AW-1:0] A_F2     = AW'(8'hF2);

   state_t        r_state, r_tgt, w_state_nxt, w_tgt_nxt, w_follow;
   logic [4:0]    r_idx, w_idx_nxt, w_len;
   logic [TW-1:0] r_tmo, w_tmo_nxt;
   logic [2:0]    r_conf, w_conf_nxt;
   logic          r_err, w_err_nxt;
   logic          w_en, w_wr, w_flag, w_last, w_done, w_seq_done;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;

   // Transaction decode from registered state and step index.
   always_comb begin
      w_en   = 1'b0;
      w_wr   = 1'b0;
      w_flag = 1'b0;
      w_addr = '0;
      w_data = '0;
      w_len  = 5'd1;
      case (r_state)
         S_INIT: begin
            w_en = 1'b1; w_wr = 1'b1; w_flag = 1'b1; w_len = 5'd4;
            case (r_idx)
               5'd0:    begin w_addr = AW'(8'h02); w_data = DW'(8'h10); end
               5'd1:    w_addr = AW'(8'h02);
               5'd2:    begin w_addr = AW'(8'h10); w_data = DW'(8'hD2); end
               default: ;
            endcase
         end
         S_READ_CTE: begin
            w_en = 1'b1; w_len = 5'(1 + N_TIME + N_TMR);
            if (r_idx == 5'd0)              w_addr = A_F0;
            else if (r_idx <= 5'(N_TIME))   w_addr = TIME_BASE + AW'(r_idx) - AW'(1);
            else                            w_addr = TMR_BASE + AW'(r_idx) - AW'(N_TIME + 1);
         end
         S_CFG_HORA: begin
            w_en = 1'b1; w_len = 5'(1 + N_TMR);
            w_addr = (r_idx == 5'd0) ? A_F2 : TMR_BASE + AW'(r_idx) - AW'(1);
         end
         S_CFG_FECHA: begin
            w_en = 1'b1; w_len = 5'(5 + N_TMR);
            if (r_idx == 5'd0)      w_addr = A_F1;
            else if (r_idx <= 5'd3) w_addr = TIME_BASE + AW'(r_idx) - AW'(1);
            else if (r_idx == 5'd4) w_addr = A_F2;
            else                    w_addr = TMR_BASE + AW'(r_idx) - AW'(5);
         end
         S_CFG_TIMER: begin
            w_en = 1'b1; w_len = 5'(1 + N_TIME);
            w_addr = (r_idx == 5'd0) ? A_F1 : TIME_BASE + AW'(r_idx) - AW'(1);
         end
         S_WR_HF: begin
            w_en = 1'b1; w_wr = 1'b1; w_len = 5'(N_TIME + 1);
            w_addr = (r_idx < 5'(N_TIME)) ? TIME_BASE + AW'(r_idx) : A_F1;
         end
         S_WR_TMR: begin
            w_en = 1'b1; w_wr = 1'b1; w_len = 5'(N_TMR + 2);
            if (r_idx < 5'(N_TMR))       w_addr = TMR_BASE + AW'(r_idx);
            else if (r_idx == 5'(N_TMR)) w_addr = A_F2;
            else begin
               w_flag = 1'b1;
               w_data = DW'(8'h08);
            end
         end
         default: ;
      endcase
   end

   assign w_last = (r_idx == w_len - 5'd1);
   assign w_done = w_en & bus.in_flag_done;

   // Sequence that follows the current one once it completes.
   always_comb begin
      w_follow = S_READ_CTE;
      case (r_state)
         S_READ_CTE:
            case (bus.in_sw)
               3'b001:  w_follow = S_CFG_HORA;
               3'b010:  w_follow = S_CFG_FECHA;
               3'b100:  w_follow = S_CFG_TIMER;
               default: w_follow = S_READ_CTE;
            endcase
         S_CFG_HORA, S_CFG_FECHA:
            w_follow = (bus.in_sw == 3'b000) ? S_WR_HF : r_state;
         S_CFG_TIMER:
            w_follow = (bus.in_sw == 3'b000) ? S_WR_TMR : r_state;
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tgt_nxt   = r_tgt;
      w_idx_nxt   = r_idx;
      w_tmo_nxt   = r_tmo;
      w_conf_nxt  = r_conf;
      w_err_nxt   = r_err;
      w_seq_done  = 1'b0;
      case (r_state)
         S_IDLE, S_ERROR: begin
            w_state_nxt = S_GAP;
            w_tgt_nxt   = S_INIT;
            w_idx_nxt   = '0;
            w_tmo_nxt   = '0;
         end
         S_GAP: begin
            w_state_nxt = r_tgt;
            w_idx_nxt   = '0;
            w_tmo_nxt   = '0;
         end
         default: begin
            // A done on the last allowed cycle is accepted before the timeout fires.
            if (w_done) begin
               w_tmo_nxt = '0;
               if (w_last) begin
                  w_idx_nxt   = '0;
                  w_seq_done  = 1'b1;
                  w_state_nxt = S_GAP;
                  w_tgt_nxt   = w_follow;
                  if (r_state == S_READ_CTE) w_conf_nxt = bus.in_sw;
               end else begin
                  w_idx_nxt = r_idx + 5'd1;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 1'b1;
               w_idx_nxt   = '0;
               w_tmo_nxt   = '0;
            end else begin
               w_tmo_nxt = r_tmo + TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_tgt   <= S_INIT;
         r_idx   <= '0;
         r_tmo   <= '0;
         r_conf  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tgt   <= w_tgt_nxt;
         r_idx   <= w_idx_nxt;
         r_tmo   <= w_tmo_nxt;
         r_conf  <= w_conf_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign bus.out_funcion_conf   = r_conf;
   assign bus.out_addr_ram_rtc   = w_addr;
   assign bus.out_dato_inicio    = w_data;
   assign bus.out_flag_inicio    = w_flag;
   assign bus.out_funcion_w_r    = w_wr;
   assign bus.out_en_funcion_rtc = w_en;
   assign bus.out_busy           = w_en;
   assign bus.out_seq_done       = w_seq_done;
   assign bus.out_error          = r_err;
endmodule

// File: tb/tb_rtc_seq_ctrl_param.sv
// Self-checking bench for rtc_seq_ctrl_param: randomized done latency and switch noise
// against a transaction-list reference model.
module tb_rtc_seq_ctrl_param;
   localparam int TMO = 16;
   localparam int K_INIT = 0, K_RD = 1, K_HORA = 2, K_FECHA = 3, K_TIMER = 4, K_WRHF = 5, K_WRTMR = 6;
   localparam int M_NONE = 0, M_EXACT = 1, M_TMO = 2, M_RST = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cur_kind;
   logic       exp_err;
   logic [2:0] exp_conf;
   logic [7:0] qa[$], qd[$];
   logic       qf[$], qw[$];

   rtc_seq_ctrl_param_if #(.AW(8), .DW(8)) bus ();

   rtc_seq_ctrl_param #(.AW(8), .DW(8), .TIMEOUT(TMO)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int next_kind(input int k, input logic [2:0] sw);
      case (k)
         K_INIT:  return K_RD;
         K_RD:    return (sw == 3'b001) ? K_HORA : (sw == 3'b010) ? K_FECHA :
                         (sw == 3'b100) ? K_TIMER : K_RD;
         K_HORA:  return (sw == 3'b000) ? K_WRHF : K_HORA;
         K_FECHA: return (sw == 3'b000) ? K_WRHF : K_FECHA;
         K_TIMER: return (sw == 3'b000) ? K_WRTMR : K_TIMER;
         default: return K_RD;
      endcase
   endfunction

   task automatic push(input logic [7:0] a, input logic [7:0] d, input logic f, input logic w);
      qa.push_back(a); qd.push_back(d); qf.push_back(f); qw.push_back(w);
   endtask

   task automatic build(input int k);
      qa.delete(); qd.delete(); qf.delete(); qw.delete();
      case (k)
         K_INIT: begin
            push(8'h02, 8'h10, 1, 1); push(8'h02, 8'h00, 1, 1);
            push(8'h10, 8'hD2, 1, 1); push(8'h00, 8'h00, 1, 1);
         end
         K_RD: begin
            push(8'hF0, 0, 0, 0);
            for (int t = 0; t < 7; t++) push(8'h21 + 8'(t), 0, 0, 0);
            for (int t = 0; t < 3; t++) push(8'h41 + 8'(t), 0, 0, 0);
         end
         K_HORA: begin
            push(8'hF2, 0, 0, 0);
            for (int t = 0; t < 3; t++) push(8'h41 + 8'(t), 0, 0, 0);
         end
         K_FECHA: begin
            push(8'hF1, 0, 0, 0);
            for (int t = 0; t < 3; t++) push(8'h21 + 8'(t), 0, 0, 0);
            push(8'hF2, 0, 0, 0);
            for (int t = 0; t < 3; t++) push(8'h41 + 8'(t), 0, 0, 0);
         end
         K_TIMER: begin
            push(8'hF1, 0, 0, 0);
            for (int t = 0; t < 7; t++) push(8'h21 + 8'(t), 0, 0, 0);
         end
         K_WRHF: begin
            for (int t = 0; t < 7; t++) push(8'h21 + 8'(t), 0, 0, 1);
            push(8'hF1, 0, 0, 1);
         end
         default: begin
            for (int t = 0; t < 3; t++) push(8'h41 + 8'(t), 0, 0, 1);
            push(8'hF2, 0, 0, 1);
            push(8'h00, 8'h08, 1, 1);
         end
      endcase
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_en"},   32'(bus.out_en_funcion_rtc), 0);
      check({tag, "_addr"}, 32'(bus.out_addr_ram_rtc), 0);
      check({tag, "_data"}, 32'(bus.out_dato_inicio), 0);
      check({tag, "_flag"}, 32'(bus.out_flag_inicio), 0);
      check({tag, "_wr"},   32'(bus.out_funcion_w_r), 0);
      check({tag, "_busy"}, 32'(bus.out_busy), 0);
      check({tag, "_sdone"}, 32'(bus.out_seq_done), 0);
      check({tag, "_err"},  32'(bus.out_error), 0);
      check({tag, "_conf"}, 32'(bus.out_funcion_conf), 0);
   endtask

   task automatic run_seq(input logic [2:0] sw_final, input int mode, input int at);
      int n, d, nxt;
      build(cur_kind);
      n = qa.size();
      for (int i = 0; i < n; i++) begin
         check("txn_en",   32'(bus.out_en_funcion_rtc), 1);
         check("txn_addr", 32'(bus.out_addr_ram_rtc), 32'(qa[i]));
         check("txn_data", 32'(bus.out_dato_inicio), 32'(qd[i]));
         check("txn_flag", 32'(bus.out_flag_inicio), 32'(qf[i]));
         check("txn_wr",   32'(bus.out_funcion_w_r), 32'(qw[i]));
         check("txn_busy", 32'(bus.out_busy), 1);
         check("txn_err",  32'(bus.out_error), 32'(exp_err));
         check("txn_conf", 32'(bus.out_funcion_conf), 32'(exp_conf));
         if (mode == M_RST && i == at) begin
            reset = 1'b1;
            #1;
            check_zero("rst_async");
            tick(); tick();
            reset = 1'b0;
            exp_err = 1'b0; exp_conf = 3'b000;
            tick();
            check("rst_gap_en", 32'(bus.out_en_funcion_rtc), 0);
            tick();
            cur_kind = K_INIT;
            return;
         end
         if (i == at && mode == M_EXACT)    d = TMO - 1;
         else if (i == at && mode == M_TMO) d = TMO;
         else if (cur_kind == K_INIT)       d = 3;
         else                               d = int'($urandom_range(4));
         bus.in_sw = 3'($urandom);
         for (int k = 0; k < d; k++) begin
            tick();
            if (!(mode == M_TMO && i == at && k == d - 1))
               check("hold_en", 32'(bus.out_en_funcion_rtc), 1);
         end
         if (mode == M_TMO && i == at) begin
            check("tmo_en",   32'(bus.out_en_funcion_rtc), 0);
            check("tmo_err",  32'(bus.out_error), 1);
            check("tmo_busy", 32'(bus.out_busy), 0);
            exp_err = 1'b1;
            tick();
            check("tmo_gap_en",  32'(bus.out_en_funcion_rtc), 0);
            check("tmo_gap_err", 32'(bus.out_error), 1);
            tick();
            cur_kind = K_INIT;
            return;
         end
         if (i == n - 1) bus.in_sw = sw_final;
         bus.in_flag_done = 1'b1;
         #1;
         check("seq_done", 32'(bus.out_seq_done), (i == n - 1) ? 1 : 0);
         tick();
         bus.in_flag_done = 1'b0;
      end
      if (cur_kind == K_RD) exp_conf = sw_final;
      nxt = next_kind(cur_kind, sw_final);
      check("gap_en",   32'(bus.out_en_funcion_rtc), 0);
      check("gap_busy", 32'(bus.out_busy), 0);
      check("gap_addr", 32'(bus.out_addr_ram_rtc), 0);
      check("gap_conf", 32'(bus.out_funcion_conf), 32'(exp_conf));
      bus.in_flag_done = 1'b1;
      #1;
      check("gap_sdone", 32'(bus.out_seq_done), 0);
      tick();
      bus.in_flag_done = 1'b0;
      cur_kind = nxt;
   endtask

   initial begin
      bus.in_flag_done = 1'b0;
      bus.in_sw = 3'b000;
      exp_err = 1'b0;
      exp_conf = 3'b000;
      cur_kind = K_INIT;
      tick(); tick();
      check_zero("reset");
      reset = 1'b0;
      tick();
      check("idle_gap_en",   32'(bus.out_en_funcion_rtc), 0);
      check("idle_gap_busy", 32'(bus.out_busy), 0);
      tick();

      run_seq(3'b000, M_NONE, -1);            // INIT -> READ_CTE
      run_seq(3'b010, M_NONE, -1);            // -> CFG_FECHA
      run_seq(3'b010, M_NONE, -1);            // repeats
      run_seq(3'b000, M_NONE, -1);            // -> WR_HF
      run_seq(3'($urandom), M_NONE, -1);      // -> READ_CTE
      run_seq(3'b100, M_NONE, -1);            // -> CFG_TIMER
      run_seq(3'b000, M_NONE, -1);            // -> WR_TMR
      run_seq(3'($urandom), M_NONE, -1);      // -> READ_CTE
      run_seq(3'b011, M_NONE, -1);            // multi-bit -> READ_CTE
      run_seq(3'b001, M_NONE, -1);            // -> CFG_HORA
      run_seq(3'b000, M_EXACT, 2);            // done on last allowed cycle -> WR_HF
      run_seq(3'b110, M_NONE, -1);            // -> READ_CTE
      run_seq(3'b100, M_NONE, -1);            // -> CFG_TIMER
      run_seq(3'b000, M_TMO, 3);              // timeout -> ERROR -> INIT
      run_seq(3'b000, M_NONE, -1);            // INIT -> READ_CTE
      run_seq(3'b100, M_NONE, -1);            // -> CFG_TIMER
      run_seq(3'b000, M_NONE, -1);            // -> WR_TMR
      run_seq(3'b000, M_RST, 2);              // reset mid WR_TMR -> INIT
      run_seq(3'b000, M_NONE, -1);            // INIT -> READ_CTE
      run_seq(3'b101, M_NONE, -1);            // -> READ_CTE
      run_seq(3'b000, M_NONE, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
